// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory target for the MEM stage.
// Accepts one load/store at a time, waits LATENCY cycles, then presents a
// response that is held until the requester takes it.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request (req_ready = 1)
// WAIT   | request captured, counting down the access latency
// RESP   | response valid, held until resp_ready
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         ZERO_LAT = (LATENCY == 0);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [3:0]    cnt;
    logic          hold_we;
    logic [31:0]   hold_addr;
    logic [31:0]   hold_wdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    assign req_ready  = (state == S_IDLE);
    assign busy       = ~req_ready;
    assign resp_valid = (state == S_RESP);
    assign accept     = req_valid & req_ready;

    // Access operands: a zero-latency access commits on the accept edge, so it
    // must use the live request; every other access uses the captured copy.
    always_comb begin
        if (state == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = hold_we;
            acc_addr  = hold_addr;
            acc_wdata = hold_wdata;
        end
    end

    assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_idx    = acc_addr[AW+1:2];
    assign enter_resp = (accept && ZERO_LAT) || ((state == S_WAIT) && (cnt == 4'd0));

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = ZERO_LAT ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM, latency counter, request capture and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            hold_we    <= 1'b0;
            hold_addr  <= 32'd0;
            hold_wdata <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_we    <= req_we;
                hold_addr  <= req_addr;
                hold_wdata <= req_wdata;
                cnt        <= CNT_LOAD;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // Storage array is deliberately not reset; stores commit on entry to RESP
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: two instances (LATENCY 2 and 0), a
// directed vector table, hand-written reset sequences, and random traffic
// checked against a word-indexed memory model.
module tb_data_mem_responder;

    localparam int DEPTH  = 64;
    localparam int LAT_A  = 2;
    localparam int LAT_B  = 0;
    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        valid_a, valid_b;
    logic        ready_a, rv_a, err_a, busy_a;
    logic        ready_b, rv_b, err_b, busy_b;
    logic [31:0] rd_a, rd_b;

    int          sel;
    logic        o_ready, o_valid, o_err, o_busy;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_a [int];
    logic [31:0] model_b [int];

    typedef struct {
        int          s;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(valid_a), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(ready_a), .resp_valid(rv_a), .resp_ready(resp_ready),
        .resp_rdata(rd_a), .resp_err(err_a), .busy(busy_a)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(valid_b), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(ready_b), .resp_valid(rv_b), .resp_ready(resp_ready),
        .resp_rdata(rd_b), .resp_err(err_b), .busy(busy_b)
    );

    always #(PERIOD/2) clk = ~clk;

    // Route the selected instance's outputs to one set of observation signals
    always_comb begin
        if (sel == 1) begin
            o_ready = ready_b; o_valid = rv_b; o_err = err_b; o_busy = busy_b; o_rdata = rd_b;
        end else begin
            o_ready = ready_a; o_valid = rv_a; o_err = err_a; o_busy = busy_a; o_rdata = rd_a;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete access: issue, confirm latency, response, hold behaviour and release.
    task automatic access(input int s, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input bit exp_err,
                          input logic [31:0] exp_rdata, input bit chk_data, output time t_acc);
        int          lat;
        int          cyc;
        int          busy_n;
        bit          stable_bad;
        logic [31:0] s_rd;
        logic        s_err;
        lat        = (s == 1) ? LAT_B : LAT_A;
        sel        = s;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        if (s == 1) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        valid_a   = 1'b0;
        valid_b   = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        cyc    = 0;
        busy_n = 0;
        while (!o_valid && cyc < 40) begin
            if (o_busy && !o_ready) busy_n++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, lat);
        if (o_busy && !o_ready) busy_n++;
        chk("resp_err", {31'd0, o_err}, {31'd0, exp_err});
        if (chk_data) chk("resp_rdata", o_rdata, exp_rdata);
        s_rd       = o_rdata;
        s_err      = o_err;
        stable_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (o_busy && !o_ready) busy_n++;
            if (!o_valid || o_rdata !== s_rd || o_err !== s_err) stable_bad = 1'b1;
        end
        if (hold > 0) chk("hold_stable", {31'd0, stable_bad}, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("release", {o_valid, o_ready, o_busy}, 3'b010);
        chk("busy_cycles", busy_n, lat + 1 + hold);
        if (we && !exp_err) begin
            if (s == 1) model_b[int'(addr >> 2)] = wdata;
            else        model_a[int'(addr >> 2)] = wdata;
        end
    endtask

    initial begin
        time         t_acc, t_prev;
        int          lat_prev, hold_prev;
        int          cyc;
        bit          we, err, cd;
        int          s, idx, lo, hold;
        logic [31:0] addr, wdata, exp_rd;

        vecs[0]  = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 0, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h10,       32'h0,        0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 32'h0,        32'hCAFEF00D, 0, 1'b0, 32'h0};
        vecs[3]  = '{0, 1'b0, 32'h13,       32'h0,        0, 1'b1, 32'h0};
        vecs[4]  = '{0, 1'b1, 32'h100,      32'h12345678, 0, 1'b1, 32'h0};
        vecs[5]  = '{0, 1'b0, 32'h0,        32'h0,        0, 1'b0, 32'hCAFEF00D};
        vecs[6]  = '{0, 1'b0, 32'h10,       32'h0,        5, 1'b0, 32'hDEADBEEF};
        vecs[7]  = '{0, 1'b1, 32'hFC,       32'h1,        0, 1'b0, 32'h0};
        vecs[8]  = '{0, 1'b0, 32'hFC,       32'h0,        0, 1'b0, 32'h1};
        vecs[9]  = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,        0, 1'b1, 32'h0};
        vecs[10] = '{0, 1'b1, 32'h12,       32'h77,       0, 1'b1, 32'h0};
        vecs[11] = '{0, 1'b0, 32'h10,       32'h0,        0, 1'b0, 32'hDEADBEEF};
        vecs[12] = '{1, 1'b1, 32'h8,        32'h5,        0, 1'b0, 32'h0};
        vecs[13] = '{1, 1'b0, 32'h8,        32'h0,        0, 1'b0, 32'h5};

        sel        = 0;
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_a", {31'd0, ready_a}, 32'd1);
        chk("rst_valid_a", {31'd0, rv_a}, 32'd0);
        chk("rst_rdata_a", rd_a, 32'd0);
        chk("rst_err_a", {31'd0, err_a}, 32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_ready_b", {31'd0, ready_b}, 32'd1);

        t_prev    = 0;
        lat_prev  = 0;
        hold_prev = 0;
        for (int i = 0; i < 14; i++) begin
            access(vecs[i].s, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                   vecs[i].exp_err, vecs[i].exp_rdata, 1'b1, t_acc);
            if (i > 0 && vecs[i].s == vecs[i-1].s)
                chk("issue_spacing", 32'(t_acc - t_prev), 32'((lat_prev + 2 + hold_prev) * PERIOD));
            t_prev    = t_acc;
            lat_prev  = (vecs[i].s == 1) ? LAT_B : LAT_A;
            hold_prev = vecs[i].hold;
        end

        // Reset while in WAIT drops a pending store
        access(0, 1'b1, 32'h20, 32'h1111, 0, 1'b0, 32'h0, 1'b1, t_acc);
        sel = 0; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        chk("in_wait_busy", {31'd0, o_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_wait", {o_ready, o_valid, o_busy}, 3'b100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(0, 1'b0, 32'h20, 32'h0, 0, 1'b0, 32'h1111, 1'b1, t_acc);

        // Reset while in RESP keeps the committed store
        sel = 0; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hBBBB; resp_ready = 1'b0; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("resp_before_rst", {31'd0, o_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_resp", {o_ready, o_valid, o_busy}, 3'b100);
        chk("async_rst_rdata", o_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        model_a[9] = 32'hBBBB;
        access(0, 1'b0, 32'h24, 32'h0, 0, 1'b0, 32'hBBBB, 1'b1, t_acc);

        // Random traffic against the memory model
        for (int n = 0; n < 300; n++) begin
            s     = $urandom_range(0, 1);
            we    = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, DEPTH + 3);
            lo    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            addr  = 32'(idx * 4 + lo);
            if ($urandom_range(0, 15) == 0) addr = addr | 32'h8000_0000;
            wdata = $urandom;
            hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
            exp_rd = 32'h0;
            cd     = 1'b1;
            if (!we && !err) begin
                if (s == 1) begin
                    if (model_b.exists(int'(addr >> 2))) exp_rd = model_b[int'(addr >> 2)];
                    else cd = 1'b0;
                end else begin
                    if (model_a.exists(int'(addr >> 2))) exp_rd = model_a[int'(addr >> 2)];
                    else cd = 1'b0;
                end
            end
            access(s, we, addr, wdata, hold, err, exp_rd, cd, t_acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipeline's data-memory port: it accepts one load or store request at a time from the memory stage, services it after a configurable access latency, and returns a handshaked response carrying read data and an error flag. It replaces the zero-latency combinational data memory with a realistic multi-cycle target. Its `req_ready` / `resp_valid` outputs let the hazard logic stall the MEM stage while an access is outstanding.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; a power of two, at least 4.
- `LATENCY`, 2: wait cycles between request acceptance and the response; legal range 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present; `req_we`, `req_addr` and `req_wdata` must be valid while it is high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; word index is `req_addr[31:2]`.
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  requester consumes the response.
- `resp_rdata`  out  32  load data; 0 for stores and for errored accesses.
- `resp_err`  out  1  access was misaligned or out of range.
- `busy`  out  1  request accepted and not yet retired; equals `!req_ready`.

## Operation
- FSM states and transitions:
  - IDLE → WAIT on accept, when `LATENCY > 0`.
  - IDLE → RESP on accept, when `LATENCY = 0`.
  - WAIT → RESP when the counter reaches 0.
  - RESP → IDLE when `resp_valid && resp_ready`.
- Accept means `req_valid && req_ready` on a rising edge.
- `req_ready` is 1 only in IDLE, so at most one request is outstanding. There is no same-cycle accept while in RESP.
- On accept, the block captures `req_we`, `req_addr` and `req_wdata` into holding registers. Later changes on the `req_*` inputs have no effect.
- On accept, the 4-bit counter loads `LATENCY-1`. It decrements once per cycle in WAIT.
- Error check on the captured address (`resp_err = 1` if either holds):
  - misaligned: `addr[1:0] != 0`;
  - out of range: `addr[31:2] >= DEPTH_WORDS`.
- On the edge that enters RESP:
  - store without error: `mem[addr[31:2]]` is written;
  - load without error: `resp_rdata` is registered from `mem[addr[31:2]]`;
  - any errored access: no write, and `resp_rdata = 0`;
  - any store: `resp_rdata = 0`.
- While in RESP, `resp_valid`, `resp_rdata` and `resp_err` stay constant until the handshake.
- A load issued after a store to the same word returns the stored value (read-after-write ordering is guaranteed by serialization).
- The memory array is not reset; its contents are undefined until written. Only the FSM, counter, holding registers and outputs are reset.

## Timing
- Reset values (`rst` low, asynchronous): state = IDLE, `req_ready = 1`, `busy = 0`, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`, counter = 0.
- Reset mid-operation:
  - from WAIT: the request is dropped, and a pending store is never written;
  - from RESP: the response is discarded and the already-committed write stays.
- Latency: with accept at edge E0, `resp_valid` rises after edge E0+`LATENCY` (for `LATENCY = 0`, the cycle right after E0).
- The earliest next accept is the edge after the response handshake. With `resp_ready` held at 1, minimum issue spacing is `LATENCY+2` cycles.
- `resp_ready` held low keeps RESP indefinitely, with outputs stable.
- Outputs are registered or decoded from state only; there is no combinational path from `req_*` to `resp_*`.

## Test plan
- **Reset check:** hold `rst` low for 3 cycles, then release → `req_ready = 1`, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`.
- **Store/load, LATENCY = 2, `resp_ready = 1`:**
  - store 0xDEADBEEF to 0x10 → `resp_valid` high exactly 2 cycles after the accept edge, `resp_err = 0`, `resp_rdata = 0`;
  - then load 0x10 → `resp_rdata = 0xDEADBEEF`;
  - `req_ready` is low for 3 cycles per access.
- **Error cases:**
  - load 0x13 → `resp_err = 1`, `resp_rdata = 0`;
  - store 0x12345678 to byte address 4*`DEPTH_WORDS` → `resp_err = 1`;
  - then load 0x0 → returns its previously written value, showing no wrap-around write.
- **Backpressure:**
  - hold `resp_ready = 0` for 5 cycles after `resp_valid` → outputs stable and `req_ready = 0` throughout;
  - change `req_addr` during WAIT → response reflects the captured address.
- **LATENCY = 0 variant:** store 0x5 to 0x8, then load 0x8 → `resp_valid` the cycle after accept with data 0x5; issue spacing is 2 cycles.
- **Reset during WAIT:** store 0xAAAA to 0x20 over prior content 0x1111, and pull `rst` low in WAIT → later load of 0x20 returns 0x1111.
